systolic_pe: RTL and testbench
==============================

// Module: systolic_pe
// PURPOSE
//  Weight-stationary MAC processing element; tile of the Mini_NPU systolic array.
//  Holds one preloaded signed weight and takes an unsigned pixel stream with valid.
//  PASS mode: adds pixel*weight to sum_in from the PE above.
//  ACC mode: accumulates a fixed number of beats locally, then emits one result.
//  Pixels are forwarded east, registered, so PEs chain.
// PARAMETERS
//  DATA_W   8   pixel width, unsigned
//  WGT_W    8   weight width, signed two's complement
//  ACC_W    18  partial-sum / accumulator width, signed
//  CNT_W    8   width of beat counter and cfg_acc_len
// PORTS
//  clk           in   1        rising-edge clock
//  rst           in   1        asynchronous, active-high reset
//  w_load        in   1        capture w_in into weight register this edge
//  w_in          in   WGT_W    weight to preload
//  cfg_mode      in   1        0 = PASS, 1 = ACC; sampled only in S_IDLE
//  cfg_acc_len   in   CNT_W    ACC beats per result; 0 treated as 1
//  pix_valid_in  in   1        pixel/sum_in beat valid
//  pix_in        in   DATA_W   pixel, unsigned
//  sum_in        in   ACC_W    partial sum from north, aligned with pix_in
//  pix_valid_out out  1        pix_valid_in delayed 1 cycle
//  pix_out       out  DATA_W   pix_in delayed 1 cycle
//  sum_valid_out out  1        sum_out holds a new result this cycle
//  sum_out       out  ACC_W    result
//  busy          out  1        high while in S_ACC
// BEHAVIOUR
//  Reset: weight, pix_out, sum_out, counter = 0; valids, busy = 0; FSM in S_IDLE.
//  Product: {1'b0,pix_in} signed * weight, sign-extended to ACC_W; adds wrap mod 2^ACC_W.
//  w_load: weight updates at the edge. A beat on that same edge uses the OLD weight.
//  Pixel path: pix_out/pix_valid_out register pix_in/pix_valid_in every cycle, both modes.
//  FSM states: S_IDLE, S_ACC. Transitions:
//   S_IDLE, cfg_mode=0: each valid beat -> sum_out = prod + sum_in next cycle,
//     sum_valid_out = 1 (1-cycle latency). No beat -> sum_valid_out = 0, sum_out holds.
//   S_IDLE, cfg_mode=1, valid beat -> latch len = max(cfg_acc_len,1); acc = prod;
//     cnt = 1; go to S_ACC. If len == 1: emit now and stay in S_IDLE.
//   S_ACC, valid beat: acc += prod; cnt++. When cnt reaches len: sum_out = acc,
//     sum_valid_out pulses 1 cycle, go to S_IDLE. sum_in is ignored in ACC mode.
//   S_ACC, no beat: hold; bubbles allowed, no timeout.
//  cfg_mode and cfg_acc_len changes while busy have no effect until S_IDLE.
//  Back-to-back ACC results: the beat after the final beat may start the next group
//  (return to S_IDLE and the new start share no cycle; first beat of next group is accepted).
//  Async reset mid-group discards the partial accumulator; no sum_valid_out.
// CONFIGURATION
//  Macro PE_SATURATE_EN:
//   defined: every add clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; further adds start
//   from the clamped value.
//   undefined: plain two's-complement wrap.
// STRUCTURE
//  npu_pkg: typedef enum logic {PE_PASS, PE_ACC} pe_mode_e; pe_state_e {S_IDLE,S_ACC}.
//  Sub-module pe_mac_add (combinational): product, sign-extend, add.
//  Saturation lives only in pe_mac_add, guarded by PE_SATURATE_EN.
// TESTING
//  PASS: w=-128, pix=255, sum_in=0 -> next cycle sum_out=-32640, sum_valid_out=1.
//  PASS chain: pix=10, w=3, sum_in=100 -> sum_out=130; pix_out=10 one cycle later.
//  ACC: len=4, 4 beats pix=200, w=100, one bubble between beats 2 and 3
//       -> a single pulse with sum_out=80000, busy low after it.
//  Overflow: ACC, len=8, pix=200, w=100 -> 131071 with PE_SATURATE_EN,
//       -102144 without.
//  w_load with a beat on the same edge: w 2->5, pix=7 -> 14; next beat pix=7 -> 35.
//  rst asserted at beat 2 of len=4 -> all outputs 0 at once; new group of 4 gives correct sum.

Source files
------------

// File: rtl/npu_pkg.sv
// npu_pkg: shared types for the Mini_NPU systolic array tiles.
//   pe_mode_e  : processing-element operating mode (PASS / ACC)
//   pe_state_e : processing-element control state (S_IDLE / S_ACC)
package npu_pkg;

  typedef enum logic {
    PE_PASS = 1'b0,
    PE_ACC  = 1'b1
  } pe_mode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } pe_state_e;

endpackage

// File: rtl/pe_mac_add.sv
// pe_mac_add: combinational multiply-add for one systolic PE.
//   result = addend + sign_extend({1'b0, pix} * weight)
// Ports:
//   pix     in  DATA_W  unsigned pixel
//   weight  in  WGT_W   signed weight
//   addend  in  ACC_W   signed partial sum / accumulator
//   result  out ACC_W   signed sum
// Build option: define PE_SATURATE_EN to clamp the sum to the signed ACC_W
// range; otherwise the sum wraps modulo 2^ACC_W.
module pe_mac_add #(
  parameter int DATA_W = 8,
  parameter int WGT_W  = 8,
  parameter int ACC_W  = 18
) (
  input  logic [DATA_W-1:0]        pix,
  input  logic signed [WGT_W-1:0]  weight,
  input  logic signed [ACC_W-1:0]  addend,
  output logic signed [ACC_W-1:0]  result
);

  localparam int PROD_W = DATA_W + 1 + WGT_W;

  logic signed [DATA_W:0]   pix_s;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W:0]    sum_wide;

`ifdef PE_SATURATE_EN
  // One guard bit is enough: a single add of two ACC_W values cannot
  // overflow ACC_W+1 bits.
  function automatic logic signed [ACC_W-1:0] sat(input logic signed [ACC_W:0] v);
    if (v[ACC_W] != v[ACC_W-1])
      return v[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return v[ACC_W-1:0];
  endfunction
`endif

  // Zero-extend the pixel by one bit so it multiplies as a non-negative signed value.
  assign pix_s    = signed'({1'b0, pix});
  assign prod     = PROD_W'(pix_s) * PROD_W'(weight);
  assign prod_ext = ACC_W'(prod);
  assign sum_wide = (ACC_W+1)'(addend) + (ACC_W+1)'(prod_ext);

`ifdef PE_SATURATE_EN
  assign result = sat(sum_wide);
`else
  assign result = sum_wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/systolic_pe.sv
// systolic_pe: weight-stationary MAC processing element of the Mini_NPU array.
// Holds a preloaded signed weight; consumes an unsigned pixel stream.
//   PASS mode: sum_out = sum_in + pix*weight, one cycle after each valid beat.
//   ACC mode : accumulates cfg_acc_len beats locally (0 means 1), emits one result.
// Pixels are forwarded east through a register in both modes.
// Ports:
//   clk, rst (async, active-high)
//   w_load, w_in                 weight preload
//   cfg_mode, cfg_acc_len        mode / group length, sampled only in S_IDLE
//   pix_valid_in, pix_in, sum_in beat from west / north
//   pix_valid_out, pix_out       registered pixel forward
//   sum_valid_out, sum_out       result and its one-cycle valid
//   busy                         high while accumulating (S_ACC)
// Build option: PE_SATURATE_EN (see pe_mac_add) selects saturating adds.
module systolic_pe
  import npu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int WGT_W  = 8,
  parameter int ACC_W  = 18,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_load,
  input  logic [WGT_W-1:0]  w_in,
  input  logic              cfg_mode,
  input  logic [CNT_W-1:0]  cfg_acc_len,
  input  logic              pix_valid_in,
  input  logic [DATA_W-1:0] pix_in,
  input  logic [ACC_W-1:0]  sum_in,
  output logic              pix_valid_out,
  output logic [DATA_W-1:0] pix_out,
  output logic              sum_valid_out,
  output logic [ACC_W-1:0]  sum_out,
  output logic              busy
);

  pe_mode_e                 mode;
  pe_state_e                state_p1, state_nx;
  logic signed [WGT_W-1:0]  weight_p0;
  logic signed [ACC_W-1:0]  acc_p1, acc_nx;
  logic signed [ACC_W-1:0]  mac_addend, mac_result;
  logic [CNT_W-1:0]         cnt_p1, cnt_nx, len_p1, len_nx;
  logic [CNT_W-1:0]         cfg_len_eff, cnt_inc;
  logic [ACC_W-1:0]         sum_nx;
  logic                     sum_vld_nx;

  assign mode        = pe_mode_e'(cfg_mode);
  assign cfg_len_eff = (cfg_acc_len == '0) ? CNT_W'(1) : cfg_acc_len;
  assign cnt_inc     = cnt_p1 + CNT_W'(1);
  assign busy        = (state_p1 == S_ACC);

  // The first beat of an ACC group starts from zero; sum_in is ignored in ACC mode.
  always_comb begin
    mac_addend = '0;
    if (state_p1 == S_ACC)
      mac_addend = acc_p1;
    else if (mode == PE_PASS)
      mac_addend = signed'(sum_in);
  end

  pe_mac_add #(
    .DATA_W (DATA_W),
    .WGT_W  (WGT_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .pix    (pix_in),
    .weight (weight_p0),
    .addend (mac_addend),
    .result (mac_result)
  );

  always_comb begin
    state_nx   = state_p1;
    acc_nx     = acc_p1;
    cnt_nx     = cnt_p1;
    len_nx     = len_p1;
    sum_nx     = sum_out;
    sum_vld_nx = 1'b0;
    case (state_p1)
      S_IDLE: begin
        if (pix_valid_in) begin
          if (mode == PE_PASS) begin
            sum_nx     = mac_result;
            sum_vld_nx = 1'b1;
          end else begin
            len_nx = cfg_len_eff;
            acc_nx = mac_result;
            cnt_nx = CNT_W'(1);
            // Single-beat groups complete immediately without entering S_ACC.
            if (cfg_len_eff == CNT_W'(1)) begin
              sum_nx     = mac_result;
              sum_vld_nx = 1'b1;
            end else begin
              state_nx = S_ACC;
            end
          end
        end
      end
      S_ACC: begin
        if (pix_valid_in) begin
          acc_nx = mac_result;
          cnt_nx = cnt_inc;
          if (cnt_inc == len_p1) begin
            sum_nx     = mac_result;
            sum_vld_nx = 1'b1;
            state_nx   = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // ---- register boundary: weight, pixel forward, FSM and result ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weight_p0     <= '0;
      pix_out       <= '0;
      pix_valid_out <= 1'b0;
      state_p1      <= S_IDLE;
      acc_p1        <= '0;
      cnt_p1        <= '0;
      len_p1        <= '0;
      sum_out       <= '0;
      sum_valid_out <= 1'b0;
    end else begin
      if (w_load)
        weight_p0 <= signed'(w_in);
      pix_out       <= pix_in;
      pix_valid_out <= pix_valid_in;
      state_p1      <= state_nx;
      acc_p1        <= acc_nx;
      cnt_p1        <= cnt_nx;
      len_p1        <= len_nx;
      sum_out       <= sum_nx;
      sum_valid_out <= sum_vld_nx;
    end
  end

endmodule

// File: tb/tb_systolic_pe.sv
module tb_systolic_pe;

  localparam int DATA_W = 8;
  localparam int WGT_W  = 8;
  localparam int ACC_W  = 18;
  localparam int CNT_W  = 8;

  logic              clk;
  logic              rst;
  logic              w_load;
  logic [WGT_W-1:0]  w_in;
  logic              cfg_mode;
  logic [CNT_W-1:0]  cfg_acc_len;
  logic              pix_valid_in;
  logic [DATA_W-1:0] pix_in;
  logic [ACC_W-1:0]  sum_in;
  logic              pix_valid_out;
  logic [DATA_W-1:0] pix_out;
  logic              sum_valid_out;
  logic [ACC_W-1:0]  sum_out;
  logic              busy;

  systolic_pe #(
    .DATA_W (DATA_W),
    .WGT_W  (WGT_W),
    .ACC_W  (ACC_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .w_load        (w_load),
    .w_in          (w_in),
    .cfg_mode      (cfg_mode),
    .cfg_acc_len   (cfg_acc_len),
    .pix_valid_in  (pix_valid_in),
    .pix_in        (pix_in),
    .sum_in        (sum_in),
    .pix_valid_out (pix_valid_out),
    .pix_out       (pix_out),
    .sum_valid_out (sum_valid_out),
    .sum_out       (sum_out),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: spec-level view of the PE.
  longint m_w;
  longint m_sum;
  bit     m_sv;
  bit     m_busy;
  longint m_len;
  longint m_pix;
  bit     m_pv;
  longint grp[$];   // products of the ACC group in progress

  localparam longint ACC_MAX = (longint'(1) <<< (ACC_W-1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W-1));

  function automatic longint addw(input longint a, input longint b);
    longint s;
    s = a + b;
`ifdef PE_SATURATE_EN
    if (s > ACC_MAX) s = ACC_MAX;
    else if (s < ACC_MIN) s = ACC_MIN;
`else
    s = s & ((longint'(1) <<< ACC_W) - 1);
    if (s > ACC_MAX) s = s - (longint'(1) <<< ACC_W);
`endif
    return s;
  endfunction

  function automatic longint fold();
    longint r;
    r = 0;
    foreach (grp[i]) r = addw(r, grp[i]);
    return r;
  endfunction

  function automatic logic [31:0] s18(input longint v);
    logic [ACC_W-1:0] t;
    t = v[ACC_W-1:0];
    return {{(32-ACC_W){1'b0}}, t};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pix_out", {24'b0, pix_out}, m_pix[31:0]);
    chk("pix_valid_out", {31'b0, pix_valid_out}, {31'b0, m_pv});
    chk("sum_valid_out", {31'b0, sum_valid_out}, {31'b0, m_sv});
    chk("busy", {31'b0, busy}, {31'b0, m_busy});
    chk("sum_out", {{(32-ACC_W){1'b0}}, sum_out}, s18(m_sum));
  endtask

  // One clock: drive a beat, advance the model by the spec rules, check #1 after the edge.
  task automatic step(input logic v, input logic [7:0] p, input logic [17:0] s,
                      input logic wl, input logic [7:0] wi, input logic m, input logic [7:0] l);
    longint prod, len;
    pix_valid_in = v; pix_in = p; sum_in = s; w_load = wl; w_in = wi;
    cfg_mode = m; cfg_acc_len = l;
    @(posedge clk);
    prod  = longint'(p) * m_w;
    m_sv  = 0;
    m_pix = longint'(p);
    m_pv  = v;
    if (!m_busy) begin
      if (v) begin
        if (!m) begin
          m_sum = addw(longint'($signed(s)), prod);
          m_sv  = 1;
        end else begin
          len = (l == 0) ? 1 : longint'(l);
          m_len = len;
          grp.delete();
          grp.push_back(prod);
          if (len == 1) begin
            m_sum = fold();
            m_sv  = 1;
          end else begin
            m_busy = 1;
          end
        end
      end
    end else if (v) begin
      grp.push_back(prod);
      if (longint'(grp.size()) == m_len) begin
        m_sum  = fold();
        m_sv   = 1;
        m_busy = 0;
      end
    end
    if (wl) m_w = longint'($signed(wi));
    #1;
    check_all();
  endtask

  task automatic idle(input logic m, input logic [7:0] l);
    step(1'b0, 8'd0, 18'd0, 1'b0, 8'd0, m, l);
  endtask

  task automatic load_w(input logic [7:0] wi);
    step(1'b0, 8'd0, 18'd0, 1'b1, wi, 1'b0, 8'd0);
  endtask

  // Asynchronous reset between edges; outputs must clear immediately.
  task automatic do_reset();
    @(negedge clk);
    pix_valid_in = 1'b0;
    rst = 1'b1;
    #1;
    m_w = 0; m_sum = 0; m_sv = 0; m_busy = 0; m_len = 0; m_pix = 0; m_pv = 0;
    grp.delete();
    chk("rst_sum_out", {{(32-ACC_W){1'b0}}, sum_out}, 32'd0);
    chk("rst_sum_valid", {31'b0, sum_valid_out}, 32'd0);
    chk("rst_pix_out", {24'b0, pix_out}, 32'd0);
    chk("rst_pix_valid", {31'b0, pix_valid_out}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; w_load = 1'b0; w_in = '0; cfg_mode = 1'b0; cfg_acc_len = '0;
    pix_valid_in = 1'b0; pix_in = '0; sum_in = '0;
    m_w = 0; m_sum = 0; m_sv = 0; m_busy = 0; m_len = 0; m_pix = 0; m_pv = 0;
    do_reset();

    // Weight is zero after reset: product vanishes, sum_in passes through.
    step(1'b1, 8'd50, 18'd7, 1'b0, 8'd0, 1'b0, 8'd0);
    chk("zero_weight", {{(32-ACC_W){1'b0}}, sum_out}, s18(7));

    // PASS, most negative product.
    load_w(8'h80);
    step(1'b1, 8'd255, 18'd0, 1'b0, 8'd0, 1'b0, 8'd0);
    chk("pass_neg", {{(32-ACC_W){1'b0}}, sum_out}, s18(-32640));
    chk("pass_neg_vld", {31'b0, sum_valid_out}, 32'd1);
    idle(1'b0, 8'd0);
    chk("pass_hold", {{(32-ACC_W){1'b0}}, sum_out}, s18(-32640));

    // PASS chain.
    load_w(8'd3);
    step(1'b1, 8'd10, 18'd100, 1'b0, 8'd0, 1'b0, 8'd0);
    chk("pass_chain", {{(32-ACC_W){1'b0}}, sum_out}, s18(130));
    chk("pass_pix_fwd", {24'b0, pix_out}, 32'd10);

    // ACC len=4 with a bubble between beats 2 and 3.
    load_w(8'd100);
    step(1'b1, 8'd200, 18'd5, 1'b0, 8'd0, 1'b1, 8'd4);
    step(1'b1, 8'd200, 18'd5, 1'b0, 8'd0, 1'b0, 8'd1);   // config changes ignored while busy
    idle(1'b1, 8'd4);
    step(1'b1, 8'd200, 18'd5, 1'b0, 8'd0, 1'b1, 8'd4);
    step(1'b1, 8'd200, 18'd5, 1'b0, 8'd0, 1'b1, 8'd4);
    chk("acc4", {{(32-ACC_W){1'b0}}, sum_out}, s18(80000));
    chk("acc4_vld", {31'b0, sum_valid_out}, 32'd1);
    idle(1'b1, 8'd4);
    chk("acc4_busy_low", {31'b0, busy}, 32'd0);

    // Overflow, len=8, back-to-back after a length-1 group (cfg_acc_len=0).
    step(1'b1, 8'd3, 18'd0, 1'b0, 8'd0, 1'b1, 8'd0);
    chk("len0_as_1", {{(32-ACC_W){1'b0}}, sum_out}, s18(300));
    for (int i = 0; i < 8; i++) step(1'b1, 8'd200, 18'd0, 1'b0, 8'd0, 1'b1, 8'd8);
`ifdef PE_SATURATE_EN
    chk("acc8_ovf", {{(32-ACC_W){1'b0}}, sum_out}, s18(131071));
`else
    chk("acc8_ovf", {{(32-ACC_W){1'b0}}, sum_out}, s18(-102144));
`endif
    // Next group starts on the very next beat.
    for (int i = 0; i < 2; i++) step(1'b1, 8'd1, 18'd0, 1'b0, 8'd0, 1'b1, 8'd2);
    chk("b2b_group", {{(32-ACC_W){1'b0}}, sum_out}, s18(200));

    // Weight load on the same edge as a beat uses the old weight.
    load_w(8'd2);
    step(1'b1, 8'd7, 18'd0, 1'b1, 8'd5, 1'b0, 8'd0);
    chk("wload_old", {{(32-ACC_W){1'b0}}, sum_out}, s18(14));
    step(1'b1, 8'd7, 18'd0, 1'b0, 8'd0, 1'b0, 8'd0);
    chk("wload_new", {{(32-ACC_W){1'b0}}, sum_out}, s18(35));

    // Reset mid-group, then a clean group of 4.
    load_w(8'd100);
    step(1'b1, 8'd200, 18'd0, 1'b0, 8'd0, 1'b1, 8'd4);
    do_reset();
    load_w(8'd100);
    for (int i = 0; i < 4; i++) step(1'b1, 8'd200, 18'd0, 1'b0, 8'd0, 1'b1, 8'd4);
    chk("post_rst_acc", {{(32-ACC_W){1'b0}}, sum_out}, s18(80000));

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), 18'($urandom),
           $urandom_range(0, 15) == 0, 8'($urandom),
           1'($urandom_range(0, 1)), 8'($urandom_range(0, 5)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
